// File: rtl/edt_tdr_pkg.sv
// Shared layout helpers for the EDT IJTAG control TDR: field offsets, shift length
// and elaboration-time parameter sanity checks.
package edt_tdr_pkg;

  function automatic int unsigned tdr_len(input int unsigned dr_w,
                                          input int unsigned st_w,
                                          input bit          lock_en);
    return dr_w + st_w + (lock_en ? 32'd2 : 32'd0);
  endfunction

  function automatic int unsigned data_lsb();
    return 32'd0;
  endfunction

  function automatic int unsigned status_lsb(input int unsigned dr_w);
    return dr_w;
  endfunction

  function automatic int unsigned viol_pos(input int unsigned dr_w,
                                           input int unsigned st_w);
    return dr_w + st_w;
  endfunction

  function automatic int unsigned lock_pos(input int unsigned dr_w,
                                           input int unsigned st_w);
    return dr_w + st_w + 32'd1;
  endfunction

  // RESET_VALUE is untyped so a width slip by the integrator is caught here.
  function automatic bit params_ok(input int unsigned dr_w,
                                   input int unsigned rv_w);
    return (dr_w >= 32'd1) && (rv_w == dr_w);
  endfunction

endpackage

// File: rtl/edt_tdr_persistent_buf.sv
// Stand-in for the library persistent buffer cell; the netlist flow swaps in the
// keep-cell so each control output has its own unmergeable driver.
module edt_tdr_persistent_buf (
  input  logic a_i,
  output logic y_o
);

  assign y_o = a_i;

endmodule

// File: rtl/edt_ijtag_param_ctrl_tdr.sv
// Parametrised IJTAG TDR for EDT/scan control: static control bits with optional
// write lock, capture-only status bits, negedge-retimed scan out.
module edt_ijtag_param_ctrl_tdr
  import edt_tdr_pkg::*;
#(
  parameter int unsigned DR_WIDTH     = 4,
  parameter int unsigned STATUS_WIDTH = 2,
  parameter              RESET_VALUE  = 4'b0,
  parameter bit          LOCK_EN      = 1'b1,
  localparam int unsigned SW_P        = (STATUS_WIDTH > 0) ? STATUS_WIDTH : 1
) (
  input  logic                ijtag_tck,
  input  logic                ijtag_reset,
  input  logic                ijtag_sel,
  input  logic                ijtag_si,
  input  logic                ijtag_ce,
  input  logic                ijtag_se,
  input  logic                ijtag_ue,
  input  logic [SW_P-1:0]     status_in,
  output logic [DR_WIDTH-1:0] data_out,
  output logic                locked,
  output logic                ijtag_so
);

  localparam int unsigned L        = tdr_len(DR_WIDTH, STATUS_WIDTH, LOCK_EN);
  localparam int unsigned DATA_LSB = data_lsb();
  localparam int unsigned ST_LSB   = status_lsb(DR_WIDTH);
  localparam int unsigned VIOL_POS = viol_pos(DR_WIDTH, STATUS_WIDTH);
  localparam int unsigned LOCK_POS = lock_pos(DR_WIDTH, STATUS_WIDTH);
  localparam logic [DR_WIDTH-1:0] RST_DATA = DR_WIDTH'(RESET_VALUE);

  if (!params_ok(DR_WIDTH, $bits(RESET_VALUE))) begin : g_param_err
    $error("edt_ijtag_param_ctrl_tdr: DR_WIDTH must be >=1 and match RESET_VALUE width");
  end

  logic [L-1:0]        tdr_q, tdr_d;
  logic [L-1:0]        cap_img;
  logic [L-1:0]        shift_img;
  logic                so_q;
  logic [DR_WIDTH-1:0] data_q, data_d;
  logic                lock_q, viol_q;
  logic                upd_en;

  assign upd_en = ijtag_sel & ijtag_ue;

  // Capture image assembled field by field so absent fields leave no vectors behind.
  assign cap_img[DATA_LSB +: DR_WIDTH] = data_q;

  if (STATUS_WIDTH > 0) begin : g_status
    assign cap_img[ST_LSB +: STATUS_WIDTH] = status_in;
  end

  if (LOCK_EN) begin : g_lock_cap
    assign cap_img[VIOL_POS] = viol_q;
    assign cap_img[LOCK_POS] = lock_q;
  end

  if (L == 1) begin : g_shift_one
    assign shift_img = ijtag_si;
  end else begin : g_shift_many
    assign shift_img = {ijtag_si, tdr_q[L-1:1]};
  end

  always_comb begin
    tdr_d = tdr_q;
    if (ijtag_sel && ijtag_ce) begin
      tdr_d = cap_img;
    end else if (ijtag_sel && ijtag_se) begin
      tdr_d = shift_img;
    end
  end

  // Shift path is deliberately unreset; its contents are only meaningful after capture.
  always_ff @(posedge ijtag_tck) begin
    tdr_q <= tdr_d;
  end

  always_ff @(negedge ijtag_tck) begin
    so_q <= tdr_q[0];
  end

  assign ijtag_so = so_q;

  if (LOCK_EN) begin : g_lock
    logic lock_d, viol_d;

    // A locked register ignores updates and remembers that someone tried.
    always_comb begin
      data_d = data_q;
      lock_d = lock_q;
      viol_d = viol_q;
      if (upd_en) begin
        if (!lock_q) begin
          data_d = tdr_q[DATA_LSB +: DR_WIDTH];
          lock_d = tdr_q[LOCK_POS];
        end else begin
          viol_d = 1'b1;
        end
      end
    end

    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
        data_q <= RST_DATA;
        lock_q <= 1'b0;
        viol_q <= 1'b0;
      end else begin
        data_q <= data_d;
        lock_q <= lock_d;
        viol_q <= viol_d;
      end
    end
  end else begin : g_nolock
    always_comb begin
      data_d = data_q;
      if (upd_en) begin
        data_d = tdr_q[DATA_LSB +: DR_WIDTH];
      end
    end

    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
        data_q <= RST_DATA;
      end else begin
        data_q <= data_d;
      end
    end

    assign lock_q = 1'b0;
    assign viol_q = 1'b0;
  end

  for (genvar i = 0; i < DR_WIDTH; i++) begin : g_data_buf
    edt_tdr_persistent_buf u_data_buf (
      .a_i (data_q[i]),
      .y_o (data_out[i])
    );
  end

  edt_tdr_persistent_buf u_lock_buf (
    .a_i (lock_q),
    .y_o (locked)
  );

endmodule

// File: tb/tb_edt_ijtag_param_ctrl_tdr.sv
// Self-checking bench: directed scenarios plus random IJTAG traffic against a
// queue-based model of the scan register and its control/lock state.
module tb_edt_ijtag_param_ctrl_tdr;

  logic       ijtag_tck = 1'b0;
  logic       ijtag_reset;
  logic       ijtag_sel, ijtag_si, ijtag_ce, ijtag_se, ijtag_ue;
  logic [1:0] status_in;
  logic [3:0] data_out;
  logic       locked;
  logic       ijtag_so;

  int errors = 0;
  int checks = 0;

  always #5 ijtag_tck = ~ijtag_tck;

  edt_ijtag_param_ctrl_tdr #(
    .DR_WIDTH     (4),
    .STATUS_WIDTH (2),
    .RESET_VALUE  (4'b0101),
    .LOCK_EN      (1'b1)
  ) dut (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .ijtag_sel   (ijtag_sel),
    .ijtag_si    (ijtag_si),
    .ijtag_ce    (ijtag_ce),
    .ijtag_se    (ijtag_se),
    .ijtag_ue    (ijtag_ue),
    .status_in   (status_in),
    .data_out    (data_out),
    .locked      (locked),
    .ijtag_so    (ijtag_so)
  );

  // Model: scan chain as a bit queue, element 0 nearest scan-out.
  bit         m_q[$];
  logic [3:0] m_data;
  bit         m_lock, m_viol;
  bit         m_valid, m_so_valid;
  bit         m_so;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = 4'b0101;
    m_lock = 1'b0;
    m_viol = 1'b0;
  endtask

  task automatic model_negedge(input bit sel, input bit ue, input bit rst_active);
    if (m_valid) begin
      m_so       = m_q[0];
      m_so_valid = 1'b1;
    end
    if (!rst_active && sel && ue && m_valid) begin
      if (!m_lock) begin
        for (int i = 0; i < 4; i++) m_data[i] = m_q[i];
        m_lock = m_q[7];
      end else begin
        m_viol = 1'b1;
      end
    end
  endtask

  task automatic model_posedge(input bit sel, input bit ce, input bit se, input bit si);
    if (sel && ce) begin
      m_q.delete();
      for (int i = 0; i < 4; i++) m_q.push_back(m_data[i]);
      m_q.push_back(status_in[0]);
      m_q.push_back(status_in[1]);
      m_q.push_back(m_viol);
      m_q.push_back(m_lock);
      m_valid = 1'b1;
    end else if (sel && se && m_valid) begin
      void'(m_q.pop_front());
      m_q.push_back(si);
    end
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ".data_out"}, 32'(data_out), 32'(m_data));
    check_eq({where, ".locked"}, 32'(locked), 32'(m_lock));
    if (m_so_valid) check_eq({where, ".so"}, 32'(ijtag_so), 32'(m_so));
  endtask

  // One TCK period, entered and left just after a rising edge.
  task automatic cycle(input bit sel, input bit ce, input bit se, input bit ue,
                       input bit si, output logic so_o);
    ijtag_sel = sel; ijtag_ce = ce; ijtag_se = se; ijtag_ue = ue; ijtag_si = si;
    @(negedge ijtag_tck);
    model_negedge(sel, ue, 1'b0);
    #1;
    check_outputs("cyc");
    so_o = ijtag_so;
    @(posedge ijtag_tck);
    model_posedge(sel, ce, se, si);
    #1;
  endtask

  task automatic capture();
    logic b;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, b);
  endtask

  task automatic update();
    logic b;
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, b);
  endtask

  task automatic shift_byte(input logic [7:0] v, output logic [7:0] so_b);
    logic b;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, v[k], b);
      so_b[k] = b;
    end
  endtask

  // Reset pulse landing between edges while a shift or update is in progress.
  task automatic reset_during(input bit se, input bit ue, input bit si);
    ijtag_sel = 1'b1; ijtag_ce = 1'b0; ijtag_se = se; ijtag_ue = ue; ijtag_si = si;
    #2 ijtag_reset = 1'b0;
    model_reset();
    #1;
    check_eq("rst_async.data_out", 32'(data_out), 32'h5);
    check_eq("rst_async.locked", 32'(locked), 32'h0);
    @(negedge ijtag_tck);
    model_negedge(1'b1, ue, 1'b1);
    #1;
    check_outputs("rst_hold");
    @(posedge ijtag_tck);
    model_posedge(1'b1, 1'b0, se, si);
    #1 ijtag_reset = 1'b1;
    check_outputs("rst_rel");
    ijtag_se = 1'b0; ijtag_ue = 1'b0;
  endtask

  initial begin
    logic [7:0] sob;
    logic       b;

    ijtag_reset = 1'b0;
    ijtag_sel = 1'b0; ijtag_si = 1'b0; ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0;
    status_in = 2'b00;
    m_q = {0, 0, 0, 0, 0, 0, 0, 0};
    m_valid = 1'b0; m_so_valid = 1'b0; m_so = 1'b0;
    model_reset();

    @(posedge ijtag_tck);
    @(posedge ijtag_tck);
    #1;
    check_eq("reset.data_out", 32'(data_out), 32'h5);
    check_eq("reset.locked", 32'(locked), 32'h0);
    ijtag_reset = 1'b1;

    // Reset image scanned out
    capture();
    shift_byte(8'h00, sob);
    check_eq("t1.so_image", 32'(sob), 32'h05);

    // Plain write
    shift_byte(8'h0A, sob);
    update();
    check_eq("t2.data_out", 32'(data_out), 32'hA);
    check_eq("t2.locked", 32'(locked), 32'h0);

    // Status capture
    status_in = 2'b11;
    capture();
    shift_byte(8'h00, sob);
    check_eq("t3.so_image", 32'(sob), 32'h3A);

    // Lock, then blocked write flags a violation
    status_in = 2'b00;
    shift_byte(8'h83, sob);
    update();
    check_eq("t4.lock_data", 32'(data_out), 32'h3);
    check_eq("t4.locked", 32'(locked), 32'h1);
    shift_byte(8'h0F, sob);
    update();
    check_eq("t4.frozen_data", 32'(data_out), 32'h3);
    capture();
    shift_byte(8'h00, sob);
    check_eq("t4.so_image", 32'(sob), 32'hC3);

    // Reset during shift and during update
    shift_byte(8'h0A, sob);
    reset_during(1'b1, 1'b0, 1'b1);
    reset_during(1'b0, 1'b1, 1'b0);
    check_eq("t5.data_out", 32'(data_out), 32'h5);
    check_eq("t5.locked", 32'(locked), 32'h0);
    capture();
    shift_byte(8'h00, sob);
    check_eq("t5.so_image", 32'(sob), 32'h05);

    // Deselected register ignores all controls
    shift_byte(8'hA5, sob);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), b);
    end
    check_eq("t6.data_out", 32'(data_out), 32'h5);
    check_eq("t6.locked", 32'(locked), 32'h0);
    shift_byte(8'h00, sob);
    check_eq("t6.tdr_held", 32'(sob), 32'hA5);

    // Random traffic
    capture();
    for (int n = 0; n < 500; n++) begin
      int unsigned op;
      status_in = 2'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        reset_during(1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        op = $urandom_range(0, 9);
        case (op)
          0, 1:    cycle(1'($urandom_range(0, 3) != 0), 1'b1, 1'b0, 1'b0, 1'($urandom), b);
          2:       cycle(1'($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'b1, 1'($urandom), b);
          3:       cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'($urandom), b);
          4:       cycle(1'($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'b0, 1'($urandom), b);
          default: cycle(1'($urandom_range(0, 3) != 0), 1'b0, 1'b1, 1'b0, 1'($urandom), b);
        endcase
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
